bcd_seg7_scanner: RTL
=====================

// Module: bcd_seg7_scanner
// PURPOSE
//  Downstream display stage for the BCD digit counters. Takes NUM_DIGITS packed BCD digits
//  and drives a time-multiplexed common-anode 7-segment display.
//  Snapshots all digits once per frame, so the display never shows a mix of old and new values.
//  Decodes BCD to segments, blanks leading zeros, and shows a dash for non-BCD codes.
// PARAMETERS
//  NUM_DIGITS  4     number of display digits, 1..8; digit 0 is least significant
//  PRESCALE    1000  clk cycles per digit slot, >=1
//  LZB_EN      1     1 = leading-zero blanking on, 0 = all digits always shown
// PORTS
//  clk          in   1              clock, rising edge
//  rst_n        in   1              asynchronous, active-low reset
//  en           in   1              scan enable; 0 = display off, counters frozen
//  digits_in    in   4*NUM_DIGITS   BCD digits; digit i = digits_in[4i+3:4i]
//  dp_in        in   NUM_DIGITS     decimal point request per digit, 1 = lit
//  an_n         out  NUM_DIGITS     digit anode select, active low, one-hot-low or all high
//  seg_n        out  7              segments {g,f,e,d,c,b,a}, active low
//  dp_n         out  1              decimal point, active low
//  frame_start  out  1              1-cycle pulse, new frame snapshot taken
// BEHAVIOUR
//  Reset (async, immediate)
//   - Internal state: pre_cnt=0, idx=0, shadow digits/dp=0.
//   - Outputs: an_n=all 1, seg_n=7'h7F, dp_n=1, frame_start=0.
//  Prescaler (en=1)
//   - pre_cnt counts 0..PRESCALE-1, then wraps to 0.
//   - tick = (pre_cnt==PRESCALE-1) & en.
//  Digit index
//   - On tick: idx <= idx+1, wrapping NUM_DIGITS-1 -> 0.
//   - Each slot lasts exactly PRESCALE cycles; one frame lasts NUM_DIGITS*PRESCALE cycles.
//  Snapshot
//   - On the edge where tick & idx==NUM_DIGITS-1: shadow <= {digits_in, dp_in}.
//   - frame_start <= 1 on that same edge; 0 on all other edges.
//   - Input changes at any other time affect only the next frame.
//  Output timing
//   - All outputs are registered from the current idx and shadow values.
//   - Outputs follow an idx change one clk later.
//  Decode, per shadow digit d
//   - 0:1000000  1:1111001  2:0100100  3:0110000  4:0011001
//   - 5:0010010  6:0000010  7:1111000  8:0000000  9:0010000
//   - Codes A..F: dash, 0111111.
//   - dp_n = ~shadow_dp[idx].
//  Leading-zero blanking (LZB_EN=1)
//   - Digit i>0 is blanked when, for every j>=i, digit j==0 and shadow_dp[j]==0.
//   - Digit 0 is never blanked.
//   - A blanked slot drives an_n=all 1, seg_n=7F, dp_n=1.
//  Active slot
//   - an_n has bit idx low and all other bits high.
//  en=0
//   - pre_cnt, idx and shadow hold their values; no snapshot is taken.
//   - Next edge: an_n=all 1, seg_n=7F, dp_n=1, frame_start=0.
//   - On re-enable, scanning resumes at the held idx/pre_cnt; outputs are valid one cycle later.
//  PRESCALE=1: idx advances every enabled cycle.
//  NUM_DIGITS=1: every tick is a frame boundary.
// TESTING (NUM_DIGITS=4, PRESCALE=4, LZB_EN=1 unless stated)
//  T1 Reset release, en=1, digits=16'h0000, dp=0
//     -> an_n=1110 with seg_n=1000000 for 4 cycles.
//     -> then an_n=1111 for 12 cycles; pattern repeats.
//     -> frame_start pulses every 16 cycles.
//  T2 digits=16'h1234
//     -> after frame_start: slots show 4/3/2/1 (0011001, 0110000, 0100100, 1111001).
//     -> an_n=1110, 1101, 1011, 0111, 4 cycles each.
//  T3 digits 16'h0042 -> 16'h0977 changed during slot 1
//     -> rest of the frame still shows 2, 4, blank, blank.
//     -> next frame shows 7, 7, 9, blank.
//  T4 digits=16'h00A5
//     -> slot1 seg_n=0111111 (dash), slot0 shows 5, slots 2 and 3 blanked.
//     -> with LZB_EN=0: slots 2 and 3 show 0 (1000000).
//  T5 digits=16'h0001, dp_in=4'b0100
//     -> slot3 blank; slot2 shows 0 with dp_n=0; slot1 shows 0; slot0 shows 1.
//  T6 en=0 for 10 cycles mid-slot 2, then rst_n pulsed low mid-frame
//     -> en=0: an_n=1111 next cycle; scanning resumes in slot 2 with the remaining count.
//     -> rst_n low: all outputs go to reset values immediately, before any clk edge.

Source files
------------

// File: rtl/bcd_seg7_scanner.sv
// Time-multiplexed common-anode 7-segment scanner: BCD decode, leading-zero blanking, per-frame snapshot.
// Latency: outputs are registered and follow a digit-index change one clk later; new inputs appear at the next frame.
// Backpressure: none; en=0 freezes the scan state and blanks the display on the next edge.
module bcd_seg7_scanner #(
    parameter int NUM_DIGITS = 4,
    parameter int PRESCALE   = 1000,
    parameter int LZB_EN     = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    output logic [NUM_DIGITS-1:0]   an_n,
    output logic [6:0]              seg_n,
    output logic                    dp_n,
    output logic                    frame_start
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);
    localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);

    logic [PW-1:0]                 pre_cnt;
    logic [IW-1:0]                 idx;
    logic [NUM_DIGITS-1:0][3:0]    shadow_dig;
    logic [NUM_DIGITS-1:0]         shadow_dp;
    logic [NUM_DIGITS-1:0]         blank;
    logic                          tick;
    logic                          snap;
    logic                          zero_above;

    assign tick = (pre_cnt == PRE_MAX) & en;
    assign snap = tick & (idx == IDX_MAX);

    // Segment pattern {g,f,e,d,c,b,a}, active low; non-BCD codes show a dash.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 7'b1000000;
            4'd1:    seg_decode = 7'b1111001;
            4'd2:    seg_decode = 7'b0100100;
            4'd3:    seg_decode = 7'b0110000;
            4'd4:    seg_decode = 7'b0011001;
            4'd5:    seg_decode = 7'b0010010;
            4'd6:    seg_decode = 7'b0000010;
            4'd7:    seg_decode = 7'b1111000;
            4'd8:    seg_decode = 7'b0000000;
            4'd9:    seg_decode = 7'b0010000;
            default: seg_decode = 7'b0111111;
        endcase
    endfunction

    // Slot prescaler and digit index; both hold while disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt <= '0;
            idx     <= '0;
        end else if (en) begin
            pre_cnt <= (pre_cnt == PRE_MAX) ? '0 : pre_cnt + 1'b1;
            if (tick)
                idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
        end
    end

    // Frame snapshot: digits/dp are captured only at the frame boundary so a frame is never mixed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_dig  <= '0;
            shadow_dp   <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= snap;
            if (snap) begin
                shadow_dig <= digits_in;
                shadow_dp  <= dp_in;
            end
        end
    end

    // Leading-zero mask: digit i>0 blanks while it and everything above it is zero with no dp.
    always_comb begin
        blank      = '0;
        zero_above = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_above = zero_above & (shadow_dig[i] == 4'd0) & ~shadow_dp[i];
            blank[i]   = (LZB_EN != 0) & zero_above;
        end
    end

    // Registered display drive from the current index and snapshot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_n  <= '1;
            seg_n <= 7'h7F;
            dp_n  <= 1'b1;
        end else if (!en || blank[idx]) begin
            an_n  <= '1;
            seg_n <= 7'h7F;
            dp_n  <= 1'b1;
        end else begin
            an_n  <= ~(NUM_DIGITS'(1) << idx);
            seg_n <= seg_decode(shadow_dig[idx]);
            dp_n  <= ~shadow_dp[idx];
        end
    end

endmodule
